// File: rtl/radix4_mult_pkg.sv
// ============================================================================
//  Module      : radix4_mult_pkg
//  Description : Shared types and constants for the radix-4 multiplier sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package radix4_mult_pkg;

    localparam int BEATS     = 16;
    localparam int OP_W      = 32;
    localparam int PROD_W    = 64;
    localparam int DEF_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        WAIT  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [OP_W-1:0]      a;
        logic [OP_W-1:0]      b;
        logic [DEF_TAG_W-1:0] tag;
    } op_entry_t;

endpackage

`default_nettype wire

// File: rtl/radix4_mult_seq_op_fifo.sv
// ============================================================================
//  Module      : op_fifo
//  Description : Synchronous operand FIFO with wrap-bit pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_fifo
    import radix4_mult_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      CLK,
    input  logic      rst_n,
    input  logic      push,
    input  op_entry_t wr_data,
    input  logic      pop,
    output op_entry_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    op_entry_t      r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_push;
    logic           w_pop;

    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the head slot, so a push at full is legal then.
    assign w_push  = push & (~full | pop);
    assign w_pop   = pop & ~empty;
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/radix4_mult_seq.sv
// ============================================================================
//  Module      : radix4_mult_seq
//  Description : Issue/collect sequencer around the 16-beat radix-4 Booth multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module radix4_mult_seq
    import radix4_mult_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int BEATS      = radix4_mult_pkg::BEATS
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              mul_rst_n,
    output logic              mul_valid_in,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic              mul_valid_out,
    input  logic [63:0]       mul_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_c,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy,
    output logic              err
);

    localparam int                BW          = $clog2(BEATS);
    localparam logic [BW-1:0]     c_last_beat = BW'(BEATS - 1);

    // The FIFO entry type carries a package-fixed tag width.
    if (TAG_W != DEF_TAG_W) begin : g_tag_w_chk
        $error("TAG_W must equal radix4_mult_pkg::DEF_TAG_W");
    end

    seq_state_e          r_state;
    logic [BW-1:0]       r_beat;
    logic [31:0]         r_mul_a;
    logic [31:0]         r_mul_b;
    logic [TAG_W-1:0]    r_tag;
    logic                r_first;
    logic                r_err;
    logic                r_out_valid;
    logic [63:0]         r_out_c;
    logic [TAG_W-1:0]    r_out_tag;

    op_entry_t           w_wr_entry;
    op_entry_t           w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_out_free;
    logic                w_lost;
    logic                w_capture;

    assign w_wr_entry = '{a: in_a, b: in_b, tag: in_tag};
    assign in_ready   = rst_n & ~w_full;
    assign w_push     = in_valid & in_ready;
    assign w_pop      = (r_state == IDLE) & ~w_empty;

    op_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_op_fifo (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .push    (w_push),
        .wr_data (w_wr_entry),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // The product is only guaranteed on the first WAIT cycle; later cycles are a backpressure hold.
    assign w_out_free = ~r_out_valid | out_ready;
    assign w_lost     = (r_state == WAIT) & r_first & ~mul_valid_out;
    assign w_capture  = (r_state == WAIT) & ~w_lost & w_out_free;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_tag   <= '0;
            r_first <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_mul_a <= w_head.a;
                        r_mul_b <= w_head.b;
                        r_tag   <= w_head.tag;
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_beat  <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_beat <= r_beat + 1'b1;
                    if (r_beat == c_last_beat) begin
                        r_first <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_first <= 1'b0;
                    if (w_lost) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_capture) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_out_tag   <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_c     <= mul_c;
            r_out_tag   <= r_tag;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign mul_rst_n    = rst_n & (r_state != CLEAR);
    assign mul_valid_in = (r_state == RUN);
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign out_valid    = r_out_valid;
    assign out_c        = r_out_c;
    assign out_tag      = r_out_tag;
    assign busy         = ~w_empty | (r_state != IDLE);
    assign err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_radix4_mult_seq.sv
// ============================================================================
//  Module      : tb_radix4_mult_seq
//  Description : Scoreboard bench with a beat-accurate Booth multiplier model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_radix4_mult_seq;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        mul_rst_n;
    logic        mul_valid_in;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_valid_out;
    logic [63:0] mul_c;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_c;
    logic [3:0]  out_tag;
    logic        busy;
    logic        err;

    typedef struct {
        logic [63:0] c;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic        kill_vo = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    radix4_mult_seq u_dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_tag        (in_tag),
        .mul_rst_n     (mul_rst_n),
        .mul_valid_in  (mul_valid_in),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_valid_out (mul_valid_out),
        .mul_c         (mul_c),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_c         (out_c),
        .out_tag       (out_tag),
        .busy          (busy),
        .err           (err)
    );

    // Multiplier model: one Booth digit per beat, result and valid held once 16 beats are in.
    logic signed [63:0] m_sum;
    int                 m_cnt;
    logic               m_vo;

    function automatic logic signed [63:0] booth_pp(input logic [31:0] a, input logic [31:0] b, input int i);
        logic [32:0]        bx;
        logic [2:0]         t;
        logic signed [63:0] ax;
        logic signed [63:0] d;
        bx = {b, 1'b0};
        t  = bx[2*i +: 3];
        ax = {{32{a[31]}}, a};
        d  = -2 * 64'(t[2]) + 64'(t[1]) + 64'(t[0]);
        return (ax * d) <<< (2 * i);
    endfunction

    always @(posedge CLK) begin
        if (!mul_rst_n) begin
            m_sum <= '0;
            m_cnt <= 0;
            m_vo  <= 1'b0;
        end else if (mul_valid_in && m_cnt < 16) begin
            m_sum <= m_sum + booth_pp(mul_a, mul_b, m_cnt);
            m_cnt <= m_cnt + 1;
            m_vo  <= (m_cnt == 15);
        end
    end

    assign mul_c         = m_sum;
    assign mul_valid_out = m_vo & ~kill_vo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every consumed product must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (rst_n === 1'b1 && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got c=%h tag=%h, expected none", out_c, out_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_c", out_c, e.c);
                chk("out_tag", 64'(out_tag), 64'(e.tag));
            end
        end
    end

    int push_cyc;

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                           input logic [63:0] exp_c, input bit track);
        int n;
        @(negedge CLK);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: got in_ready=0, expected 1");
        end else begin
            @(posedge CLK);
            if (track) sb.push_back('{c: exp_c, tag: tag});
            #1;
            push_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || out_valid) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_done", 64'(sb.size() != 0 || busy || out_valid), 64'(0));
    endtask

    initial begin
        int n;
        int rst_lo;
        int vin_hi;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_mul_rst_n", 64'(mul_rst_n), 64'(0));
        chk("rst_mul_valid_in", 64'(mul_valid_in), 64'(0));
        chk("rst_mul_ab", {mul_a, mul_b}, 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_c", out_c, 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_busy_err", 64'({busy, err}), 64'(0));
        rst_n = 1'b1;
        @(negedge CLK);
        chk("in_ready_after_rst", 64'(in_ready), 64'(1));

        // 3 * 5 with latency and pulse-width checks
        push_op(32'd3, 32'd5, 4'd1, 64'h0000_0000_0000_000F, 1'b1);
        rst_lo = 0;
        vin_hi = 0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge CLK);
            rst_lo += (mul_rst_n == 1'b0) ? 1 : 0;
            vin_hi += (mul_valid_in == 1'b1) ? 1 : 0;
            n++;
        end
        chk("latency_edges", 64'(cyc - push_cyc), 64'(19));
        chk("mul_rst_n_low_cycles", 64'(rst_lo), 64'(1));
        chk("mul_valid_in_cycles", 64'(vin_hi), 64'(16));
        drain();

        push_op(32'hFFFF_FFF9, 32'd6, 4'd2, 64'hFFFF_FFFF_FFFF_FFD6, 1'b1);
        push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 64'h0000_0000_0000_0001, 1'b1);
        push_op(32'h8000_0000, 32'h8000_0000, 4'd4, 64'h4000_0000_0000_0000, 1'b1);
        push_op(32'h7FFF_FFFF, 32'h8000_0000, 4'd5, 64'hC000_0000_8000_0000, 1'b1);
        drain();

        // Backpressure: three back-to-back ops with the consumer stalled
        out_ready = 1'b0;
        push_op(32'd10, 32'd10, 4'd0, 64'h0000_0000_0000_0064, 1'b1);
        push_op(32'd2, 32'hFFFF_FFFD, 4'd1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        push_op(32'd100, 32'd100, 4'd2, 64'h0000_0000_0000_2710, 1'b1);
        @(negedge CLK);
        chk("in_ready_full", 64'(in_ready), 64'(0));
        repeat (60) @(negedge CLK);
        chk("stall_out_valid", 64'(out_valid), 64'(1));
        chk("stall_out_c_first", out_c, 64'h0000_0000_0000_0064);
        chk("stall_out_tag_first", 64'(out_tag), 64'(0));
        chk("stall_busy_vin", 64'({busy, mul_valid_in}), 64'(2'b10));
        out_ready = 1'b1;
        drain();

        // Missing valid_out on the first WAIT cycle
        kill_vo = 1'b1;
        push_op(32'd5, 32'd5, 4'd7, 64'h0, 1'b0);
        n = 0;
        while (!err && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("err_set", 64'(err), 64'(1));
        n = 0;
        while (busy && n < 10) begin
            @(negedge CLK);
            n++;
        end
        kill_vo = 1'b0;
        chk("err_no_out_valid", 64'(out_valid), 64'(0));
        push_op(32'd6, 32'd7, 4'd8, 64'h0000_0000_0000_002A, 1'b1);
        drain();
        chk("err_sticky", 64'(err), 64'(1));

        // Reset in the middle of RUN
        push_op(32'd9, 32'd9, 4'd9, 64'h0, 1'b0);
        repeat (8) @(negedge CLK);
        chk("pre_rst_in_run", 64'(mul_valid_in), 64'(1));
        rst_n = 1'b0;
        @(negedge CLK);
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_mul_valid_in", 64'(mul_valid_in), 64'(0));
        chk("midrst_err_cleared", 64'(err), 64'(0));
        rst_n = 1'b1;
        push_op(32'd2, 32'd2, 4'd3, 64'h0000_0000_0000_0004, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/radix4_mult_seq.md
Name: radix4_mult_seq

Overview:
- Issue/collect sequencer wrapped around the 16-beat radix-4 Booth multiplier (signed 32x32 -> 64).
- Upstream side: accepts operand pairs on a valid/ready handshake and buffers them in a small FIFO.
- Multiplier side: clears the multiplier's accumulator and beat counter, then holds operands stable for exactly 16 valid beats.
- Downstream side: captures the 64-bit product into an output register with valid/ready backpressure and an echoed tag.

Parameters:
- FIFO_DEPTH, 2, operand FIFO entries; power of 2, >= 2.
- TAG_W, 4, width of the user tag carried alongside each operand pair.
- BEATS, 16, multiplier beats per product; fixed at 16 for 32-bit radix-4.

Ports:
- CLK  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  32  signed multiplicand.
- in_b  in  32  signed multiplier.
- in_tag  in  TAG_W  user tag.
- mul_rst_n  out  1  to multiplier rst_n.
- mul_valid_in  out  1  to multiplier valid_in.
- mul_a  out  32  to multiplier A; held stable.
- mul_b  out  32  to multiplier B; held stable.
- mul_valid_out  in  1  from multiplier valid_out.
- mul_c  in  64  from multiplier C.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer ready.
- out_c  out  64  signed product.
- out_tag  out  TAG_W  tag of this product.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - in_ready=0 during reset, 1 afterwards.
  - mul_rst_n=0; mul_valid_in=0; mul_a=0; mul_b=0.
  - out_valid=0; out_c=0; out_tag=0; busy=0; err=0.
  - FIFO empty; FSM in IDLE.
- Reset mid-operation aborts everything: FIFO flushed, FSM to IDLE, pending output discarded.
- mul_rst_n = rst_n AND NOT clr, where clr is high only in CLEAR.
- Input handshake: transfer on in_valid & in_ready.
  - in_ready = !full. A push when full is ignored.
  - Push while full cannot occur; simultaneous push and pop are allowed at any occupancy, including full.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head into mul_a/mul_b/tag regs and go to CLEAR. The earliest pop is the cycle after the push (no bypass).
  - CLEAR (1 cycle): clr=1 so the multiplier sum and beat counter zero; mul_valid_in=0; beat counter cleared; go to RUN.
  - RUN: mul_valid_in=1 for exactly BEATS consecutive cycles. mul_a/mul_b are constant throughout. On beat BEATS-1, go to WAIT.
  - WAIT: mul_valid_in=0. mul_valid_out must be 1 on the first WAIT cycle.
    - If mul_valid_out=0 on that cycle: set err, return to IDLE, and drop the result.
    - The multiplier holds C and valid_out while valid_in=0, so WAIT may stall on backpressure.
    - Capture mul_c and tag into the output register when !out_valid | out_ready, then go to IDLE.
- Output register:
  - out_valid sets on capture and clears on out_valid & out_ready with no new capture.
  - Capture and consume in the same cycle keeps out_valid=1 with the new data.
  - out_c and out_tag stay stable while out_valid & !out_ready.
- Latency:
  - Push at cycle t: IDLE pop at t+1, CLEAR t+2, RUN t+3..t+18, WAIT capture t+19, out_valid high from t+20.
  - Back-to-back throughput: one product per 19 cycles (IDLE, CLEAR, 16 RUN, WAIT).
- Arithmetic: the sequencer does no arithmetic; out_c = mul_c bit-exact, two's-complement signed.
- err clears only on reset.

Decomposition:
- Package radix4_mult_pkg:
  - seq_state_e enum (IDLE, CLEAR, RUN, WAIT).
  - BEATS constant.
  - OP_W=32 and PROD_W=64 constants.
  - op_entry_t struct {a, b, tag}.
- Natural sub-module: op_fifo, a synchronous FIFO of op_entry_t with FIFO_DEPTH entries, full/empty flags, and pointer wrap.

Test Plan:
- Push A=3, B=5, tag=1 with out_ready=1 -> out_valid at push+20; out_c=0x000000000000000F; out_tag=1; mul_rst_n low exactly 1 cycle; mul_valid_in high exactly 16 cycles.
- A=-7 (0xFFFFFFF9), B=6 -> out_c=0xFFFFFFFFFFFFFFD6. Then A=-1, B=-1 -> out_c=0x0000000000000001, proving the accumulator clears between operations.
- A=B=0x80000000 -> out_c=0x4000000000000000. A=0x7FFFFFFF, B=0x80000000 -> out_c=0xC000000080000000.
- Push 3 pairs back-to-back with out_ready=0:
  - in_ready drops after the FIFO fills.
  - FSM stalls in WAIT with the second product and out_c holds the first.
  - Raise out_ready: three products in order, tags 0,1,2.
- Force mul_valid_out=0 at the WAIT cycle -> err=1 and sticky, no out_valid for that op; the next op completes normally.
- Assert rst_n=0 mid-RUN for 1 cycle -> FIFO empty, out_valid=0, mul_valid_in=0. A subsequent push of 2x2 -> out_c=4.
